// File: rtl/lsu_controller_pkg.sv
// rtl/lsu_controller_pkg.sv - shared types, funct3 codes and request checking for the load/store unit
package lsu_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10,
        ST_RESP   = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK         = 2'b00,
        ERR_MISALIGNED = 2'b01,
        ERR_ILLEGAL    = 2'b10,
        ERR_TIMEOUT    = 2'b11
    } lsu_error_e;

    typedef enum logic [1:0] {
        U_EXT_SEL_B = 2'b00,
        U_EXT_SEL_H = 2'b01,
        U_EXT_SEL_W = 2'b10
    } unsigned_extender_sel_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal encodings are reported ahead of misalignment.
    function automatic lsu_error_e check_req(input logic       is_store,
                                             input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = is_store ? (funct3 > F3_W)
                              : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && off[0]) ||
                     ((funct3 == F3_W) && (off != 2'b00));
        if (illegal)
            return ERR_ILLEGAL;
        else if (misaligned)
            return ERR_MISALIGNED;
        else
            return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_controller_load_align_extend.sv
// rtl/lsu_controller_load_align_extend.sv - shifts the addressed lane of a read word down and extends it
module load_align_extend
    import lsu_controller_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0]            shifted;
    logic [31:0]            uext;
    unsigned_extender_sel_e sel;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        sel = U_EXT_SEL_W;
        case (funct3)
            F3_BU:   sel = U_EXT_SEL_B;
            F3_HU:   sel = U_EXT_SEL_H;
            default: sel = U_EXT_SEL_W;
        endcase
    end

    unsigned_extender u_uext (
        .din  (shifted),
        .sel  (sel),
        .dout (uext)
    );

    always_comb begin
        result = uext;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            default: result = uext;
        endcase
    end

endmodule

// File: rtl/unsigned_extender.sv
// rtl/unsigned_extender.sv - zero-extends the low byte, half or full word of its input
module unsigned_extender
    import lsu_controller_pkg::*;
(
    input  logic [31:0]            din,
    input  unsigned_extender_sel_e sel,
    output logic [31:0]            dout
);

    always_comb begin
        dout = din;
        case (sel)
            U_EXT_SEL_B: dout = {24'd0, din[7:0]};
            U_EXT_SEL_H: dout = {16'd0, din[15:0]};
            default:     dout = din;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - sequences one RV32I load/store over a req/gnt/rvalid memory port
module lsu_controller
    import lsu_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err
);

    localparam int             CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    lsu_error_e       rsp_err_q, rsp_err_d;

    lsu_error_e  pre_err;
    logic        timed_out;
    logic [31:0] load_result;

    assign pre_err   = check_req(req_is_store, req_funct3, req_addr[1:0]);
    assign timed_out = (cnt_q == CNT_LAST);

    load_align_extend u_align (
        .rdata  (mem_rdata),
        .off    (addr_q[1:0]),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // gnt / rvalid on the final counted cycle take priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = (pre_err != ERR_OK) ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (mem_gnt)
                    state_d = is_store_q ? ST_RESP : ST_WAIT_R;
                else if (timed_out)
                    state_d = ST_RESP;
            end
            ST_WAIT_R: if (mem_rvalid || timed_out) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_REQ: begin
                mem_req = 1'b1;
                mem_we  = is_store_q;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    cnt_d      = '0;
                    rsp_data_d = 32'd0;
                    rsp_err_d  = pre_err;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (!mem_gnt && timed_out) begin
                    rsp_err_d  = ERR_TIMEOUT;
                    rsp_data_d = 32'd0;
                end
            end
            ST_WAIT_R: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    rsp_err_d  = ERR_OK;
                    rsp_data_d = load_result;
                end else if (timed_out) begin
                    rsp_err_d  = ERR_TIMEOUT;
                    rsp_data_d = 32'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= '0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= ERR_OK;
        end else begin
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign mem_addr = {addr_q[31:2], 2'b00};
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
        if (is_store_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
Load/store sequencer between the execute stage and the data-memory port.
- Accepts one RV32I load/store per transaction and checks alignment and funct3.
- Drives a req/gnt/rvalid memory handshake with byte enables.
- Aligns and sign- or zero-extends load data, then returns a response to write-back with an error code.
- Zero-extension (LBU/LHU) uses the unsigned extender selector set U_EXT_SEL_B/H/W.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in REQ plus WAIT_R before aborting with ERR_TIMEOUT; must be ≥2.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  execute stage presents a request
req_ready  out  1  controller can accept a request (IDLE only)
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: load 000/001/010/100/101, store 000/001/010
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
mem_req  out  1  memory request, held until granted
mem_we  out  1  write enable
mem_addr  out  32  word address, {req_addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
rsp_valid  out  1  response available
rsp_ready  in  1  write-back accepts response
rsp_data  out  32  extended load data; 0 for stores and errors
rsp_err  out  2  LsuError: 00 OK, 01 MISALIGNED, 10 ILLEGAL, 11 TIMEOUT

Behaviour:
Reset:
- State IDLE; registered outputs, timeout counter and all latches cleared.
- mem_req, mem_we and rsp_valid drop to 0 immediately on assertion, including mid-transaction.
- req_ready=1 once reset deasserts.

FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: req_ready=1. On req_valid, latch is_store, funct3, addr, wdata, then check:
  - ILLEGAL: load funct3 ∈ {011,110,111}, or store funct3 >010. Priority over MISALIGNED.
  - MISALIGNED: half (001/101) with addr[0]=1, or word (010) with addr[1:0]≠0.
  - On error: go to RESP, no memory access. Otherwise: go to REQ, counter=0.
- REQ: mem_req=1; mem_addr, mem_we, mem_be, mem_wdata held stable from latches.
  - On mem_gnt: store goes to RESP (rsp_err=OK, rsp_data=0); load goes to WAIT_R.
  - Minimum load latency: accept → gnt → rvalid → rsp_valid, i.e. 3 cycles with zero-wait memory.
- WAIT_R: mem_req=0. On mem_rvalid, register the aligned and extended data, then go to RESP. mem_rvalid in any other state is ignored.
- Timeout: counter increments each cycle in REQ and WAIT_R. When it reaches TIMEOUT_CYCLES-1 with no gnt (REQ) or rvalid (WAIT_R), go to RESP with ERR_TIMEOUT and rsp_data=0. gnt or rvalid arriving on that same cycle wins over timeout.
- RESP: rsp_valid=1; rsp_data and rsp_err held until rsp_ready, then go to IDLE.
  - req_ready stays 0 in RESP, so back-to-back requests cost one IDLE cycle.

Byte enables (off = addr[1:0]):
- SB: 4'b0001<<off; SH: 4'b0011<<off; SW: 4'b1111. mem_be=4'b1111 for loads.

Store data:
- SB: {4{wdata[7:0]}}; SH: {2{wdata[15:0]}}; SW: wdata.

Load extension:
- Shifted word = mem_rdata >> (8*off).
- LB/LH: sign-extend bit 7 / bit 15.
- LBU: U_EXT_SEL_B; LHU: U_EXT_SEL_H; LW: U_EXT_SEL_W (pass-through).

Decomposition:
- Shared package typedefs gains:
  - LsuState enum.
  - LsuError enum.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Reuse of the existing UnsignedExtenderSelector.
- One combinational sub-module, load_align_extend (in: rdata, off, funct3; out: 32-bit result). It instantiates the existing unsigned extender for the zero-extend cases and performs the sign-extend cases inline.

Test Plan:
1. LBU addr=0x1003, rdata=0xAABBCCDD, gnt and rvalid each one cycle after request → mem_addr=0x1000, rsp_data=0x000000AA, rsp_err=00, rsp_valid 3 cycles after accept.
2. LH addr=0x2002, rdata=0x8001_1234 → rsp_data=0xFFFF8001. Same with LHU → 0x00008001.
3. SB addr=0x3001, wdata=0x000000EF → mem_be=0010, mem_wdata=0xEFEFEFEF, mem_we=1, rsp_data=0, rsp_err=00. SH addr=0x3002 → mem_be=1100.
4. LW addr=0x4002 → rsp_err=01 with mem_req never asserted. Load funct3=011 → rsp_err=10.
5. TIMEOUT_CYCLES=8, mem_gnt held 0 → mem_req high exactly 8 cycles, then rsp_err=11. With gnt on cycle 8 instead, the request completes normally.
6. rst pulsed while in WAIT_R → mem_req=0 and rsp_valid=0 immediately; after release req_ready=1; a late mem_rvalid produces no response.
